// File: rtl/draw_pkg.sv
// Shared draw-path definitions: pair reader FSM states, default pair range and
// pair-index to word-address mapping.
package draw_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_HOLD,
      ST_FINISH
   } rd_state_t;

   localparam int DRAW_PAIR_START = 6144;
   localparam int DRAW_PAIR_END   = 6272;

   // Even word of a pair when odd=0, odd word when odd=1; caller truncates.
   function automatic logic [31:0] pair_to_addr(input logic [31:0] pair, input logic odd);
      return {pair[30:0], odd};
   endfunction

endpackage

// File: rtl/draw_rd_lat_ctr.sv
// Loadable down-counter that times the frame memory read latency.
module draw_rd_lat_ctr #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          cnt <= '0;
      else if (load)       cnt <= value;
      else if (cnt != '0)  cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/draw_pair_reader.sv
// Sweeps a pair-index range, reads even/odd words per pair and streams them out.
// Optional running checksum of accepted pairs: DRAW_READER_CHECKSUM_EN.
module draw_pair_reader
   import draw_pkg::*;
#(
   parameter int ADDR_W     = 14,
   parameter int DATA_W     = 16,
   parameter int START_PAIR = DRAW_PAIR_START,
   parameter int END_PAIR   = DRAW_PAIR_END,
   parameter int RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  rd_en,
   output logic [ADDR_W-1:0]     rd_addr_a,
   output logic [ADDR_W-1:0]     rd_addr_b,
   input  logic [DATA_W-1:0]     rd_data_a,
   input  logic [DATA_W-1:0]     rd_data_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*DATA_W-1:0]   out_data,
   output logic [ADDR_W-2:0]     out_index,
   output logic                  busy,
   output logic                  done
`ifdef DRAW_READER_CHECKSUM_EN
  ,output logic [2*DATA_W-1:0]   checksum
`endif
);

   localparam int PW = ADDR_W - 1;
   localparam int CW = 2;
   localparam logic [PW-1:0] START_P = PW'(START_PAIR);
   localparam logic [PW-1:0] END_P   = PW'(END_PAIR);
   localparam logic [31:0]   RST_A   = pair_to_addr(START_PAIR, 1'b0);
   localparam logic [31:0]   RST_B   = pair_to_addr(START_PAIR, 1'b1);

   rd_state_t     state;
   logic [PW-1:0] pair;
   logic [PW-1:0] issue_pair;
   logic [31:0]   addr_a_w, addr_b_w;
   logic          lat_zero;

   // Next pair to issue: the first one from IDLE, otherwise the successor.
   assign issue_pair = (state == ST_HOLD) ? pair + PW'(1) : START_P;
   assign addr_a_w   = pair_to_addr(32'(issue_pair), 1'b0);
   assign addr_b_w   = pair_to_addr(32'(issue_pair), 1'b1);

   draw_rd_lat_ctr #(.W(CW)) u_lat (
      .clk   (clk),
      .reset (reset),
      .load  (state == ST_ISSUE),
      .value (CW'(RD_LAT - 1)),
      .zero  (lat_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         pair      <= START_P;
         rd_en     <= 1'b0;
         rd_addr_a <= RST_A[ADDR_W-1:0];
         rd_addr_b <= RST_B[ADDR_W-1:0];
         out_valid <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef DRAW_READER_CHECKSUM_EN
         checksum  <= '0;
`endif
      end else begin
         rd_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            ST_IDLE: if (start) begin
               state     <= ST_ISSUE;
               pair      <= START_P;
               rd_en     <= 1'b1;
               rd_addr_a <= addr_a_w[ADDR_W-1:0];
               rd_addr_b <= addr_b_w[ADDR_W-1:0];
               busy      <= 1'b1;
`ifdef DRAW_READER_CHECKSUM_EN
               checksum  <= '0;
`endif
            end
            ST_ISSUE: state <= ST_WAIT;
            ST_WAIT: if (lat_zero) begin
               out_data  <= {rd_data_b, rd_data_a};
               out_index <= pair;
               out_valid <= 1'b1;
               state     <= ST_HOLD;
            end
            ST_HOLD: if (out_ready) begin
               out_valid <= 1'b0;
`ifdef DRAW_READER_CHECKSUM_EN
               checksum  <= checksum + out_data;
`endif
               // Range check comes first, so the increment never wraps.
               if (pair == END_P) begin
                  state <= ST_FINISH;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  pair      <= issue_pair;
                  rd_en     <= 1'b1;
                  rd_addr_a <= addr_a_w[ADDR_W-1:0];
                  rd_addr_b <= addr_b_w[ADDR_W-1:0];
                  state     <= ST_ISSUE;
               end
            end
            ST_FINISH: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_draw_pair_reader.sv
// Directed bench: full default sweep with stall/restart/reset, a RD_LAT=3
// instance and a single-pair instance, checked against a pair-sequence model.
module tb_draw_pair_reader;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pair_word(input int i);
      return {16'(2*i + 1), 16'(2*i)};
   endfunction

   // ---------------- main instance: defaults, RD_LAT=1 ----------------
   logic        start_m = 1'b0, rdy_m = 1'b1;
   logic        rd_en_m, ov_m, busy_m, done_m;
   logic [13:0] aa_m, ab_m;
   logic [15:0] rda_m = '0, rdb_m = '0;
   logic [31:0] od_m;
   logic [12:0] oi_m;

   // ---------------- latency-3 instance: pairs 10..12 ----------------
   logic        start_l = 1'b0, rdy_l = 1'b1;
   logic        rd_en_l, ov_l, busy_l, done_l;
   logic [13:0] aa_l, ab_l;
   logic [15:0] la[3], lb[3];
   logic [31:0] od_l;
   logic [12:0] oi_l;

   // ---------------- single-pair instance: pair 5 ----------------
   logic        start_o = 1'b0, rdy_o = 1'b1;
   logic        rd_en_o, ov_o, busy_o, done_o;
   logic [13:0] aa_o, ab_o;
   logic [15:0] rda_o = '0, rdb_o = '0;
   logic [31:0] od_o;
   logic [12:0] oi_o;

`ifdef DRAW_READER_CHECKSUM_EN
   logic [31:0] cs_m, cs_l, cs_o;
`endif

   draw_pair_reader u_main (
      .clk(clk), .reset(rst_n), .start(start_m), .rd_en(rd_en_m),
      .rd_addr_a(aa_m), .rd_addr_b(ab_m), .rd_data_a(rda_m), .rd_data_b(rdb_m),
      .out_valid(ov_m), .out_ready(rdy_m), .out_data(od_m), .out_index(oi_m),
      .busy(busy_m), .done(done_m)
`ifdef DRAW_READER_CHECKSUM_EN
     ,.checksum(cs_m)
`endif
   );

   draw_pair_reader #(.START_PAIR(10), .END_PAIR(12), .RD_LAT(3)) u_lat3 (
      .clk(clk), .reset(rst_n), .start(start_l), .rd_en(rd_en_l),
      .rd_addr_a(aa_l), .rd_addr_b(ab_l), .rd_data_a(la[2]), .rd_data_b(lb[2]),
      .out_valid(ov_l), .out_ready(rdy_l), .out_data(od_l), .out_index(oi_l),
      .busy(busy_l), .done(done_l)
`ifdef DRAW_READER_CHECKSUM_EN
     ,.checksum(cs_l)
`endif
   );

   draw_pair_reader #(.START_PAIR(5), .END_PAIR(5), .RD_LAT(1)) u_one (
      .clk(clk), .reset(rst_n), .start(start_o), .rd_en(rd_en_o),
      .rd_addr_a(aa_o), .rd_addr_b(ab_o), .rd_data_a(rda_o), .rd_data_b(rdb_o),
      .out_valid(ov_o), .out_ready(rdy_o), .out_data(od_o), .out_index(oi_o),
      .busy(busy_o), .done(done_o)
`ifdef DRAW_READER_CHECKSUM_EN
     ,.checksum(cs_o)
`endif
   );

   // Memories return word = address, RD_LAT cycles after rd_en; junk otherwise.
   always @(posedge clk) begin
      rda_m <= rd_en_m ? {2'b00, aa_m} : 16'hDEAD;
      rdb_m <= rd_en_m ? {2'b00, ab_m} : 16'hDEAD;
      rda_o <= rd_en_o ? {2'b00, aa_o} : 16'hDEAD;
      rdb_o <= rd_en_o ? {2'b00, ab_o} : 16'hDEAD;
      la[0] <= rd_en_l ? {2'b00, aa_l} : 16'hDEAD;
      lb[0] <= rd_en_l ? {2'b00, ab_l} : 16'hDEAD;
      la[1] <= la[0]; lb[1] <= lb[0];
      la[2] <= la[1]; lb[2] <= lb[1];
   end

   // ---------------- model of the main stream ----------------
   localparam int SP = 6144, EP = 6272;
   int          exp_idx = SP;
   bit          done_due = 0, stall_prev = 0, got_first = 0;
   logic [31:0] prev_data, first_data = '0, last_data = '0;
   logic [12:0] prev_idx;
   int          first_idx = -1, last_idx = -1;
   int          hs_cnt = 0, done_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_idx    = SP;
         done_due   = 0;
         stall_prev = 0;
      end else begin
         chk("done_pulse", done_m, done_due);
         if (done_m) done_cnt++;
         done_due = 0;
         if (rd_en_m) begin
            chk("rd_addr_a", aa_m, 2*exp_idx);
            chk("rd_addr_b", ab_m, 2*exp_idx + 1);
            chk("rd_en_while_valid", ov_m, 0);
         end
         if (ov_m) begin
            chk("out_index", oi_m, exp_idx);
            chk("out_data", od_m, pair_word(exp_idx));
            if (stall_prev) begin
               chk("stall_data_stable", od_m, prev_data);
               chk("stall_index_stable", oi_m, prev_idx);
            end
            if (!got_first) begin
               got_first = 1; first_data = od_m; first_idx = int'(oi_m);
            end
            if (rdy_m) begin
               hs_cnt++;
               stall_prev = 0;
               if (exp_idx == EP) begin
                  last_data = od_m; last_idx = int'(oi_m);
                  done_due  = 1;
                  exp_idx   = SP;
               end else exp_idx++;
            end else begin
               stall_prev = 1; prev_data = od_m; prev_idx = oi_m;
            end
         end else stall_prev = 0;
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int  n, hs_before, rden_stall;
      bit  stalled, restarted;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_en", rd_en_m, 0);
      chk("rst_out_valid", ov_m, 0);
      chk("rst_busy", busy_m, 0);
      chk("rst_done", done_m, 0);
      chk("rst_out_data", od_m, 0);
      chk("rst_out_index", oi_m, 0);
      chk("rst_addr_a", aa_m, 12288);
      chk("rst_addr_b", ab_m, 12289);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single pair
      start_o = 1'b1;
      @(posedge clk); #1;
      start_o = 1'b0;
      chk("one_busy", busy_o, 1);
      chk("one_rd_en", rd_en_o, 1);
      chk("one_addr_a", aa_o, 10);
      chk("one_addr_b", ab_o, 11);
      n = 0;
      while (!ov_o && n < 20) begin @(posedge clk); #1; n++; end
      chk("one_valid_seen", ov_o, 1);
      chk("one_data", od_o, 32'h000B000A);
      chk("one_index", oi_o, 5);
      @(posedge clk); #1;
      chk("one_done", done_o, 1);
      chk("one_busy_clear", busy_o, 0);
      @(posedge clk); #1;
      chk("one_done_single", done_o, 0);
`ifdef DRAW_READER_CHECKSUM_EN
      chk("one_checksum", cs_o, 32'h000B000A);
`endif

      // RD_LAT=3
      start_l = 1'b1;
      @(posedge clk); #1;
      start_l = 1'b0;
      n = 0;
      while (!ov_l && n < 20) begin @(posedge clk); #1; n++; end
      chk("lat3_first_valid_cycle", n + 1, 5);
      for (int k = 0; k < 3; k++) begin
         chk("lat3_index", oi_l, 10 + k);
         chk("lat3_data", od_l, pair_word(10 + k));
         if (k < 2) begin
            n = 0;
            do begin @(posedge clk); #1; n++; end while (!ov_l && n < 20);
            chk("lat3_pair_cost", n, 5);
         end
      end
      @(posedge clk); #1;
      chk("lat3_done", done_l, 1);

      // main sweep with stall at 6150 and ignored restart at 6160
      start_m = 1'b1;
      @(posedge clk); #1;
      start_m = 1'b0;
      chk("main_busy", busy_m, 1);
      chk("main_first_rd_en", rd_en_m, 1);
      n = 0; stalled = 0; restarted = 0; rden_stall = 0;
      while (!done_m && n < 2000) begin
         @(posedge clk); #1; n++;
         if (ov_m && oi_m == 13'd6150 && !stalled) begin
            rdy_m = 1'b0;
            repeat (5) begin @(posedge clk); #1; if (rd_en_m) rden_stall++; end
            chk("stall_busy", busy_m, 1);
            rdy_m = 1'b1;
            stalled = 1;
         end
         if (ov_m && oi_m == 13'd6160 && !restarted) begin
            start_m = 1'b1;
            @(posedge clk); #1;
            start_m = 1'b0;
            restarted = 1;
         end
      end
      chk("sweep1_done_seen", done_m, 1);
      chk("sweep1_busy_fall", busy_m, 0);
      chk("sweep1_handshakes", hs_cnt, 129);
      chk("sweep1_stall_done", stalled, 1);
      chk("sweep1_rd_en_in_stall", rden_stall, 0);
      chk("first_data", first_data, 32'h3001_3000);
      chk("first_index", first_idx, 6144);
      chk("last_data", last_data, 32'h3101_3100);
      chk("last_index", last_idx, 6272);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("sweep1_done_count", done_cnt, 1);

      // reset at pair 6200, then restart
      start_m = 1'b1;
      @(posedge clk); #1;
      start_m = 1'b0;
      n = 0;
      while (!(ov_m && oi_m == 13'd6200) && n < 2000) begin @(posedge clk); #1; n++; end
      chk("reach_6200", oi_m, 6200);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", ov_m, 0);
      chk("mid_rst_busy", busy_m, 0);
      chk("mid_rst_rd_en", rd_en_m, 0);
      chk("mid_rst_out_data", od_m, 0);
      chk("mid_rst_out_index", oi_m, 0);
      chk("mid_rst_addr_a", aa_m, 12288);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      hs_before = hs_cnt;
      start_m = 1'b1;
      @(posedge clk); #1;
      start_m = 1'b0;
      n = 0;
      while (!ov_m && n < 20) begin @(posedge clk); #1; n++; end
      chk("restart_index", oi_m, 6144);
      n = 0;
      while (!done_m && n < 2000) begin @(posedge clk); #1; n++; end
      chk("sweep2_done_seen", done_m, 1);
      chk("sweep2_handshakes", hs_cnt - hs_before, 129);
      @(posedge clk); #1;
      chk("total_done_count", done_cnt, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/draw_pair_reader.md
# draw_pair_reader

Read-side counterpart to the draw block's pair address counter. It walks a fixed range of pair indices, issues one even/odd read address pair per index to a dual-port frame memory, and captures the two returned words. Each pair is presented downstream on a valid/ready stream. It sits between the frame memory read ports and the display/compare logic in the draw path.

## Interface
- `ADDR_W`, 14: memory word-address width; the pair index is `ADDR_W-1` bits.
- `DATA_W`, 16: width of each memory read port.
- `START_PAIR`, 6144: first pair index read.
- `END_PAIR`, 6272: last pair index read, inclusive. Requires `END_PAIR >= START_PAIR`.
- `RD_LAT`, 1: memory read latency in cycles, from `rd_en` to data valid. Range 1..4.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request to begin a sweep; accepted only in IDLE.
- `rd_en`, out, 1: read strobe to both memory ports.
- `rd_addr_a`, out, ADDR_W: `{pair, 1'b0}`, the even word.
- `rd_addr_b`, out, ADDR_W: `{pair, 1'b1}`, the odd word.
- `rd_data_a`, in, DATA_W: port A read data, valid `RD_LAT` cycles after `rd_en`.
- `rd_data_b`, in, DATA_W: port B read data, same timing as port A.
- `out_valid`, out, 1: a pair is presented on the stream.
- `out_ready`, in, 1: downstream accepts the pair.
- `out_data`, out, 2*DATA_W: `{data_b, data_a}`.
- `out_index`, out, ADDR_W-1: pair index of `out_data`.
- `busy`, out, 1: a sweep is in progress.
- `done`, out, 1: one-cycle pulse after the last pair has been accepted.
- `checksum`, out, 2*DATA_W: present only with `DRAW_READER_CHECKSUM_EN` (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, WAIT, HOLD, FINISH.
- IDLE:
  - `start=1` loads `pair <= START_PAIR` and moves to ISSUE.
  - `busy` is set on the next cycle.
- ISSUE:
  - `rd_en=1` for exactly one cycle; the addresses are driven from `pair`.
  - Loads the latency counter with `RD_LAT-1`, then moves to WAIT.
- WAIT:
  - Counts down.
  - At zero, registers `rd_data_a`/`rd_data_b` into `out_data` and `pair` into `out_index`, then moves to HOLD.
- HOLD:
  - `out_valid=1`; `out_data` and `out_index` are held stable until the handshake.
  - On `out_valid && out_ready`: if `pair == END_PAIR`, move to FINISH; otherwise `pair <= pair + 1` and move to ISSUE.
- FINISH:
  - `done=1` for one cycle, `busy` clears, then the FSM returns to IDLE.
- Arithmetic and control rules:
  - The pair increment is `ADDR_W-1` bits wide. There is no wrap, because the range check precedes the increment.
  - `start` outside IDLE is ignored, with no restart or queueing.
  - `out_ready` outside HOLD is ignored.
  - `rd_addr_a`/`rd_addr_b` hold their last value when `rd_en=0`.

## Timing
- Reset values:
  - FSM = IDLE.
  - `pair = START_PAIR`.
  - `rd_en = 0`, `out_valid = 0`, `busy = 0`, `done = 0`.
  - `out_data = 0`, `out_index = 0`, `checksum = 0`.
  - `rd_addr_a = 2*START_PAIR`, `rd_addr_b = 2*START_PAIR + 1`.
- Latency:
  - `start` sampled at cycle 0 → `rd_en` at cycle 1 → `out_valid` at cycle `2 + RD_LAT`.
  - Per-pair minimum cost is `RD_LAT + 2` cycles, with `out_ready` held high.
- Sweep length: a full sweep emits `END_PAIR - START_PAIR + 1` pairs; 129 with the defaults.
- `START_PAIR == END_PAIR`: exactly one pair, then `done`.
- Backpressure: `out_ready` low in HOLD stalls indefinitely; no further `rd_en` is issued.
- `done` timing: asserted the cycle after the final handshake; `busy` falls in that same cycle.
- Reset asserted mid-sweep: all outputs go to their reset values immediately (asynchronously), and no `done` pulse is produced.

## Configuration
- Macro: `DRAW_READER_CHECKSUM_EN`.
- Defined:
  - `checksum` accumulates the wrap-around sum mod 2^(2*DATA_W) of every accepted `out_data`.
  - It is cleared when `start` is accepted and is held after `done`.
- Undefined: the `checksum` port and its accumulator are absent.

## Structure
- Shared package `draw_pkg` holds:
  - the FSM state enum `rd_state_t`;
  - the default constants `DRAW_PAIR_START = 6144` and `DRAW_PAIR_END = 6272`;
  - a `pair_to_addr` function (even and odd forms).
- Natural sub-module: `draw_rd_lat_ctr`, the loadable down-counter for `RD_LAT`, with ports `load`, `value`, and `zero`.
- Everything else lives in the top module.

## Test plan
- Reset then `start`, `out_ready=1`, `RD_LAT=1`, memory returns `word = address`:
  - 129 handshakes occur.
  - The first `out_data = {16'd12289, 16'd12288}` with `out_index = 6144`.
  - The last `out_data = {16'd12545, 16'd12544}` with `out_index = 6272`.
  - `done` pulses once, the cycle after the last handshake.
- `out_ready` low for 5 cycles in HOLD on pair 6150:
  - `out_data` and `out_index` stay stable;
  - no `rd_en` occurs;
  - the stream resumes with 6151.
- `start` pulsed again while `busy`: ignored; the sweep still emits exactly 129 pairs.
- `RD_LAT=3`: `out_valid` first rises 5 cycles after the `start` sample, and data matches the delayed memory model.
- Reset asserted at pair 6200:
  - outputs go to reset values, with `rd_addr_a = 12288`;
  - a fresh `start` restarts at 6144.
- With `DRAW_READER_CHECKSUM_EN`, `START_PAIR = END_PAIR = 5`, memory returning `word = address`:
  - one pair `{16'd11, 16'd10}` is emitted;
  - `checksum = 32'h000B000A`.
